video_timing_pattern_gen: RTL and testbench

//  Parametrised raster timing generator with a built-in multi-mode test-pattern source and frame/second counters.

---
 rtl/video_timing_pattern_gen_if.sv | 30 +++
 rtl/video_timing_pattern_gen.sv | 134 +++++++++++++
 tb/tb_video_timing_pattern_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_pattern_gen_if.sv
// Video output bundle between the timing/pattern generator and the VGA path.
// Carries the pattern controls in and the aligned raster outputs back.
interface video_timing_pattern_gen_if #(
    parameter int CW    = 4,
    parameter int SEC_W = 4
);
    logic [1:0]      mode;
    logic [3*CW-1:0] solid_rgb;
    logic [10:0]     hcount;
    logic [10:0]     vcount;
    logic            hsync;
    logic            vsync;
    logic            blank;
    logic [3*CW-1:0] rgb;
    logic            frame_start;
    logic [7:0]      frame_count;
    logic [SEC_W-1:0] second_count;

    modport master (
        input  mode, solid_rgb,
        output hcount, vcount, hsync, vsync, blank, rgb,
        output frame_start, frame_count, second_count
    );

    modport slave (
        output mode, solid_rgb,
        input  hcount, vcount, hsync, vsync, blank, rgb,
        input  frame_start, frame_count, second_count
    );
endinterface

// File: rtl/video_timing_pattern_gen.sv
// Raster timing generator with frame-synchronous test patterns
// and frame/second counters; all outputs registered, latency 1.
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 4,
    parameter int FPS      = 60,
    parameter int SEC_W    = 4,
    parameter int CHK_LOG2 = 5
) (
    input logic clock,
    input logic reset_n,
    video_timing_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] HT_M1  = 11'(H_TOTAL - 1);
    localparam logic [10:0] VT_M1  = 11'(V_TOTAL - 1);
    localparam logic [10:0] HA     = 11'(H_ACTIVE);
    localparam logic [10:0] VA     = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] H_HALF = 11'(H_ACTIVE / 2);
    localparam logic [10:0] V_HALF = 11'(V_ACTIVE / 2);
    localparam logic [10:0] BAR_M1 = 11'(H_ACTIVE / 8 - 1);
    localparam logic [7:0]  FPS_M1 = 8'(FPS - 1);
    localparam logic [CW-1:0] MAX  = {CW{1'b1}};

    logic [10:0]     h, v, h_nxt, v_nxt;
    logic [10:0]     bar_cnt, bar_cnt_nxt;
    logic [2:0]      bar_idx, bar_idx_nxt, code;
    logic [1:0]      mode_q, mode_eff;
    logic            first_px, hs_c, vs_c, blank_c;
    logic [3*CW-1:0] pat;

    // Next raster position and bar-width counter aligned with h
    always_comb begin
        h_nxt       = h + 11'd1;
        v_nxt       = v;
        bar_cnt_nxt = bar_cnt + 11'd1;
        bar_idx_nxt = bar_idx;
        if (h == HT_M1) begin
            h_nxt       = '0;
            v_nxt       = (v == VT_M1) ? '0 : v + 11'd1;
            bar_cnt_nxt = '0;
            bar_idx_nxt = '0;
        end else if (bar_cnt == BAR_M1) begin
            bar_cnt_nxt = '0;
            bar_idx_nxt = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
        end
    end

    // Decode of the current internal pixel; new mode applies from pixel (0,0)
    always_comb begin
        first_px = (h == '0) && (v == '0);
        mode_eff = first_px ? vid.mode : mode_q;
        hs_c     = (h >= HS_BEG) && (h < HS_END);
        vs_c     = (v >= VS_BEG) && (v < VS_END);
        blank_c  = (h >= HA) || (v >= VA);
        code     = 3'd7 - bar_idx;
        pat      = '0;
        unique case (mode_eff)
            2'd0: pat = {(h >= v) ? MAX : '0,
                         (h > H_HALF) ? MAX : '0,
                         (v > V_HALF) ? MAX : '0};
            2'd1: pat = {{CW{code[2]}}, {CW{code[1]}}, {CW{code[0]}}};
            2'd2: pat = {3*CW{h[CHK_LOG2] ^ v[CHK_LOG2]}};
            2'd3: pat = vid.solid_rgb;
        endcase
    end

    // Internal raster counters and frame-latched mode
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h       <= '0;
            v       <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            mode_q  <= '0;
        end else begin
            h       <= h_nxt;
            v       <= v_nxt;
            bar_cnt <= bar_cnt_nxt;
            bar_idx <= bar_idx_nxt;
            if (first_px) mode_q <= vid.mode;
        end
    end

    // Registered outputs, all describing the same pixel
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vid.hcount      <= '0;
            vid.vcount      <= '0;
            vid.hsync       <= ~SYNC_POL;
            vid.vsync       <= ~SYNC_POL;
            vid.blank       <= 1'b1;
            vid.rgb         <= '0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.hcount      <= h;
            vid.vcount      <= v;
            vid.hsync       <= hs_c ? SYNC_POL : ~SYNC_POL;
            vid.vsync       <= vs_c ? SYNC_POL : ~SYNC_POL;
            vid.blank       <= blank_c;
            vid.rgb         <= blank_c ? '0 : pat;
            vid.frame_start <= first_px;
        end
    end

    // Frame and second counters advance on the frame_start pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vid.frame_count  <= '0;
            vid.second_count <= '0;
        end else if (vid.frame_start) begin
            if (vid.frame_count == FPS_M1) begin
                vid.frame_count  <= '0;
                vid.second_count <= vid.second_count + SEC_W'(1);
            end else begin
                vid.frame_count <= vid.frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Directed bench for video_timing_pattern_gen on a small 24x12 raster.
// Table vectors for patterns plus sequences for timing, mode sync, reset.
module tb_video_timing_pattern_gen;
    logic clock;
    logic reset_n;
    int n_chk;
    int n_fail;

    video_timing_pattern_gen_if #(.CW(4), .SEC_W(2)) vif ();

    video_timing_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .CW(4), .FPS(3), .SEC_W(2), .CHK_LOG2(1)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .vid(vif.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  mode;
        int          x;
        int          y;
        logic [11:0] solid;
        logic [11:0] exp_rgb;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic goto_px(input int x, input int y);
        for (int i = 0; i < 600; i++) begin
            if (vif.hcount == 11'(x) && vif.vcount == 11'(y)) return;
            @(negedge clock);
        end
        n_chk++;
        n_fail++;
        $display("FAIL goto: pixel (%0d,%0d) not reached", x, y);
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            if (vif.frame_start === 1'b1) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_frame: no frame_start");
    endtask

    function automatic logic [11:0] split_rgb(input int x, input int y);
        logic [11:0] c;
        if (x >= 16 || y >= 8) return 12'h000;
        c = {(x >= y) ? 4'hF : 4'h0,
             (x > 8)  ? 4'hF : 4'h0,
             (y > 4)  ? 4'hF : 4'h0};
        return c;
    endfunction

    initial begin
        int ex, ey, efc, esc;
        logic [1:0] cur_mode;
        n_chk = 0;
        n_fail = 0;

        vecs[0]  = '{2'd0, 10, 3, 12'h000, 12'hFF0};
        vecs[1]  = '{2'd0, 9,  5, 12'h000, 12'hFFF};
        vecs[2]  = '{2'd0, 2,  2, 12'h000, 12'hF00};
        vecs[3]  = '{2'd0, 17, 2, 12'h000, 12'h000};
        vecs[4]  = '{2'd0, 3,  6, 12'h000, 12'h00F};
        vecs[5]  = '{2'd1, 0,  1, 12'h000, 12'hFFF};
        vecs[6]  = '{2'd1, 1,  1, 12'h000, 12'hFFF};
        vecs[7]  = '{2'd1, 2,  1, 12'h000, 12'hFF0};
        vecs[8]  = '{2'd1, 3,  1, 12'h000, 12'hFF0};
        vecs[9]  = '{2'd1, 4,  1, 12'h000, 12'hF0F};
        vecs[10] = '{2'd1, 6,  1, 12'h000, 12'hF00};
        vecs[11] = '{2'd1, 8,  1, 12'h000, 12'h0FF};
        vecs[12] = '{2'd1, 9,  1, 12'h000, 12'h0FF};
        vecs[13] = '{2'd1, 14, 1, 12'h000, 12'h000};
        vecs[14] = '{2'd1, 15, 1, 12'h000, 12'h000};
        vecs[15] = '{2'd2, 0,  0, 12'h000, 12'h000};
        vecs[16] = '{2'd2, 2,  0, 12'h000, 12'hFFF};
        vecs[17] = '{2'd2, 2,  2, 12'h000, 12'h000};
        vecs[18] = '{2'd2, 1,  3, 12'h000, 12'hFFF};
        vecs[19] = '{2'd3, 5,  5, 12'h5A3, 12'h5A3};
        vecs[20] = '{2'd3, 7,  2, 12'h3C1, 12'h3C1};
        vecs[21] = '{2'd3, 20, 5, 12'h5A3, 12'h000};
        vecs[22] = '{2'd3, 3,  9, 12'h5A3, 12'h000};

        vif.mode = 2'd0;
        vif.solid_rgb = 12'h000;
        reset_n = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_hcount", 32'(vif.hcount), 0);
        chk("rst_vcount", 32'(vif.vcount), 0);
        chk("rst_hsync", 32'(vif.hsync), 1);
        chk("rst_vsync", 32'(vif.vsync), 1);
        chk("rst_blank", 32'(vif.blank), 1);
        chk("rst_rgb", 32'(vif.rgb), 0);
        chk("rst_fstart", 32'(vif.frame_start), 0);
        chk("rst_fcount", 32'(vif.frame_count), 0);
        chk("rst_scount", 32'(vif.second_count), 0);

        reset_n = 1'b1;
        @(negedge clock);

        ex = 0; ey = 0; efc = 0; esc = 0;
        for (int n = 0; n < 15 * 288; n++) begin
            chk("hcount", 32'(vif.hcount), 32'(ex));
            chk("vcount", 32'(vif.vcount), 32'(ey));
            chk("hsync", 32'(vif.hsync), (ex >= 18 && ex <= 21) ? 0 : 1);
            chk("vsync", 32'(vif.vsync), (ey >= 9 && ey <= 10) ? 0 : 1);
            chk("blank", 32'(vif.blank), (ex < 16 && ey < 8) ? 0 : 1);
            chk("rgb_split", 32'(vif.rgb), 32'(split_rgb(ex, ey)));
            chk("frame_start", 32'(vif.frame_start),
                (ex == 0 && ey == 0) ? 1 : 0);
            chk("frame_count", 32'(vif.frame_count), 32'(efc));
            chk("second_count", 32'(vif.second_count), 32'(esc));
            if (ex == 0 && ey == 0) begin
                if (efc == 2) begin
                    efc = 0;
                    esc = (esc + 1) % 4;
                end else begin
                    efc = efc + 1;
                end
            end
            ex = ex + 1;
            if (ex == 24) begin
                ex = 0;
                ey = (ey == 11) ? 0 : ey + 1;
            end
            @(negedge clock);
        end

        goto_px(0, 4);
        vif.mode = 2'd2;
        goto_px(10, 5);
        chk("sync_old_10_5", 32'(vif.rgb), 32'h0FFF);
        goto_px(2, 7);
        chk("sync_old_2_7", 32'(vif.rgb), 32'h000F);
        goto_px(0, 0);
        chk("sync_new_0_0", 32'(vif.rgb), 32'h0000);
        goto_px(2, 0);
        chk("sync_new_2_0", 32'(vif.rgb), 32'h0FFF);
        goto_px(2, 2);
        chk("sync_new_2_2", 32'(vif.rgb), 32'h0000);

        cur_mode = 2'd2;
        for (int i = 0; i < NV; i++) begin
            vif.solid_rgb = vecs[i].solid;
            if (vecs[i].mode != cur_mode) begin
                vif.mode = vecs[i].mode;
                cur_mode = vecs[i].mode;
                wait_frame();
            end
            goto_px(vecs[i].x, vecs[i].y);
            chk($sformatf("vec%0d_rgb", i), 32'(vif.rgb),
                32'(vecs[i].exp_rgb));
        end

        goto_px(19, 2);
        chk("mid_hsync_low", 32'(vif.hsync), 0);
        reset_n = 1'b0;
        #1;
        chk("arst_hsync", 32'(vif.hsync), 1);
        chk("arst_hcount", 32'(vif.hcount), 0);
        chk("arst_vcount", 32'(vif.vcount), 0);
        chk("arst_blank", 32'(vif.blank), 1);
        chk("arst_fcount", 32'(vif.frame_count), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rel_hcount", 32'(vif.hcount), 0);
        chk("rel_vcount", 32'(vif.vcount), 0);
        chk("rel_fstart", 32'(vif.frame_start), 1);
        chk("rel_fcount", 32'(vif.frame_count), 0);
        @(negedge clock);
        chk("rel2_hcount", 32'(vif.hcount), 1);
        chk("rel2_fstart", 32'(vif.frame_start), 0);
        chk("rel2_fcount", 32'(vif.frame_count), 1);
        chk("rel2_scount", 32'(vif.second_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
